// File: rtl/spi_slave_byte_if_if.sv
// Byte-side bus between the SPI target endpoint and the on-chip logic.
//
// Signals:
//   rx_data      received byte (endpoint -> logic)
//   rx_valid     one-cycle pulse, rx_data has just been updated
//   tx_data      byte offered for transmission (logic -> endpoint)
//   tx_valid     tx_data is being offered
//   tx_ready     holding register empty; an offer is taken when tx_valid & tx_ready
//   tx_underrun  one-cycle pulse, the filler byte was shifted out instead of user data
//   frame_active high while chip select is (synchronously) asserted
//   frame_end    one-cycle pulse when chip select is released
//
// Modports:
//   slave  - the SPI endpoint
//   master - the register/command logic that consumes and produces bytes
interface spi_slave_byte_if_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_underrun;
    logic       frame_active;
    logic       frame_end;

    modport slave (
        output rx_data, rx_valid, tx_ready, tx_underrun, frame_active, frame_end,
        input  tx_data, tx_valid
    );

    modport master (
        input  rx_data, rx_valid, tx_ready, tx_underrun, frame_active, frame_end,
        output tx_data, tx_valid
    );
endinterface

// File: rtl/spi_slave_byte_if.sv
// SPI target (slave) endpoint, fully synchronous to pclk.
//
// The SPI pins are oversampled through SYNC_STAGES flops (pclk must run at
// least 4x sclk). MOSI bits are assembled MSB first into bytes; MISO bytes
// come from a one-deep TX holding register, with UNDERRUN_BYTE substituted
// whenever the holding register is empty at a load event.
//
// Ports:
//   pclk, presetn  system clock (rising edge) and async active-low reset
//   sclk, cs_n     SPI clock and chip select from the master (asynchronous)
//   mosi           master-out data (asynchronous)
//   miso, miso_oe  slave-out data and its output enable
//   bus            byte-side handshake bus (slave modport)
module spi_slave_byte_if #(
    parameter bit         CPOL          = 1'b0,
    parameter bit         CPHA          = 1'b0,
    parameter int         SYNC_STAGES   = 2,
    parameter logic [7:0] UNDERRUN_BYTE = 8'hFF
) (
    input  logic pclk,
    input  logic presetn,
    input  logic sclk,
    input  logic cs_n,
    input  logic mosi,
    output logic miso,
    output logic miso_oe,
    spi_slave_byte_if_if.slave bus
);

    typedef enum logic [0:0] {ST_IDLE, ST_ACTIVE} state_t;

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic sclk_prev_q, sclk_prev_d;
    logic cs_prev_q, cs_prev_d;

    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] rx_shift_q, rx_shift_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_done_q, rx_done_d;
    logic       rx_valid_q, rx_valid_d;
    logic [7:0] tx_shift_q, tx_shift_d;
    logic [7:0] hold_q, hold_d;
    logic       hold_full_q, hold_full_d;
    logic       underrun_q, underrun_d;
    logic       frame_end_q, frame_end_d;

    logic sclk_s, cs_s, mosi_s;
    logic sclk_rise, sclk_fall, lead_edge, trail_edge;
    logic cs_fall, cs_rise, active;
    logic do_sample, do_shift, byte_done, load_evt, accept;
    logic frame_active;

    // Edge detection works on the last two synchronised samples only, so
    // every decision below is made on clean pclk-domain signals.
    always_comb begin
        sclk_s     = sclk_sync_q[SYNC_STAGES-1];
        cs_s       = cs_sync_q[SYNC_STAGES-1];
        mosi_s     = mosi_sync_q[SYNC_STAGES-1];
        sclk_rise  = sclk_s & ~sclk_prev_q;
        sclk_fall  = ~sclk_s & sclk_prev_q;
        lead_edge  = CPOL ? sclk_fall : sclk_rise;
        trail_edge = CPOL ? sclk_rise : sclk_fall;
        cs_fall    = ~cs_s & cs_prev_q;
        cs_rise    = cs_s & ~cs_prev_q;
        active     = (state_q == ST_ACTIVE);
        do_sample  = active & (CPHA ? trail_edge : lead_edge);
        do_shift   = active & (CPHA ? lead_edge : trail_edge);
        byte_done  = do_sample & (bit_cnt_q == 3'd7);
        // A shift edge seen with the bit counter at zero is the first shift
        // of a byte (CPHA=1) or the one right after an 8th sample (CPHA=0).
        // A shift edge coinciding with chip-select release is dropped.
        load_evt   = ((CPHA == 1'b0) & ~active & cs_fall)
                   | (do_shift & ~cs_rise & (bit_cnt_q == 3'd0));
        accept     = bus.tx_valid & ~hold_full_q;
    end

    // FSM next state: frames are delimited purely by synchronised cs_n.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (cs_fall) state_d = ST_ACTIVE;
            ST_ACTIVE: if (cs_rise) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: MISO is only driven while a frame is open.
    always_comb begin
        frame_active = (state_q == ST_ACTIVE);
        miso_oe      = frame_active;
        miso         = frame_active & tx_shift_q[7];
    end

    // Datapath next-state. A sample coinciding with cs_n release still
    // completes its byte; the bit counter and TX shifter are cleared after.
    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
        cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], cs_n};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
        sclk_prev_d = sclk_s;
        cs_prev_d   = cs_s;
        bit_cnt_d   = bit_cnt_q;
        rx_shift_d  = rx_shift_q;
        rx_data_d   = rx_data_q;
        rx_done_d   = byte_done;
        rx_valid_d  = rx_done_q;
        tx_shift_d  = tx_shift_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        underrun_d  = 1'b0;
        frame_end_d = active & cs_rise;

        if (do_sample) begin
            rx_shift_d = {rx_shift_q[6:0], mosi_s};
            bit_cnt_d  = bit_cnt_q + 3'd1;
        end
        if (byte_done) begin
            rx_data_d = {rx_shift_q[6:0], mosi_s};
        end
        if (active & cs_rise) begin
            bit_cnt_d = 3'd0;
        end

        if (active & cs_rise) begin
            tx_shift_d = 8'h00;
        end else if (load_evt) begin
            if (hold_full_q) begin
                tx_shift_d  = hold_q;
                hold_full_d = 1'b0;
            end else begin
                tx_shift_d = UNDERRUN_BYTE;
                underrun_d = 1'b1;
            end
        end else if (do_shift) begin
            tx_shift_d = {tx_shift_q[6:0], 1'b0};
        end

        // Accept only into an empty holding register; a byte offered on the
        // same cycle as an underrun load waits here for the next byte.
        if (accept) begin
            hold_d      = bus.tx_data;
            hold_full_d = 1'b1;
        end
    end

    // FSM state register.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Synchroniser and datapath registers; pins reset to their idle levels.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            sclk_sync_q <= {SYNC_STAGES{CPOL}};
            cs_sync_q   <= {SYNC_STAGES{1'b1}};
            mosi_sync_q <= '0;
            sclk_prev_q <= CPOL;
            cs_prev_q   <= 1'b1;
            bit_cnt_q   <= 3'd0;
            rx_shift_q  <= 8'h00;
            rx_data_q   <= 8'h00;
            rx_done_q   <= 1'b0;
            rx_valid_q  <= 1'b0;
            tx_shift_q  <= 8'h00;
            hold_q      <= 8'h00;
            hold_full_q <= 1'b0;
            underrun_q  <= 1'b0;
            frame_end_q <= 1'b0;
        end else begin
            sclk_sync_q <= sclk_sync_d;
            cs_sync_q   <= cs_sync_d;
            mosi_sync_q <= mosi_sync_d;
            sclk_prev_q <= sclk_prev_d;
            cs_prev_q   <= cs_prev_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_shift_q  <= rx_shift_d;
            rx_data_q   <= rx_data_d;
            rx_done_q   <= rx_done_d;
            rx_valid_q  <= rx_valid_d;
            tx_shift_q  <= tx_shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            underrun_q  <= underrun_d;
            frame_end_q <= frame_end_d;
        end
    end

    assign bus.rx_data      = rx_data_q;
    assign bus.rx_valid     = rx_valid_q;
    assign bus.tx_ready     = ~hold_full_q;
    assign bus.tx_underrun  = underrun_q;
    assign bus.frame_active = frame_active;
    assign bus.frame_end    = frame_end_q;

endmodule

// File: tb/tb_spi_slave_byte_if.sv
// Testbench for spi_slave_byte_if: one mode-0 instance and one mode-3
// (CPOL=1, CPHA=1) instance, each driven by a bit-banged SPI master.
// Expected results come from a byte-level model: each load event takes the
// oldest byte offered to the endpoint, or the filler byte if none is left.
module tb_spi_slave_byte_if;

    localparam int H = 4;

    logic pclk = 1'b0;
    logic presetn;
    logic sclk0, cs0, sclk1, cs1, mosi;
    logic miso0, oe0, miso1, oe1;

    int n_assert = 0;
    int n_fail   = 0;

    logic [7:0] fq0[$], fq1[$];
    logic [7:0] av0[$], av1[$];
    logic [7:0] rxq0[$], rxq1[$];
    logic [7:0] mbytes[$], rdq[$];
    bit accp0 = 1'b0, accp1 = 1'b0;
    int und0 = 0, und1 = 0, fe0 = 0, fe1 = 0;

    spi_slave_byte_if_if bus0();
    spi_slave_byte_if_if bus1();

    always #5 pclk = ~pclk;

    spi_slave_byte_if #(.CPOL(1'b0), .CPHA(1'b0)) dut0 (
        .pclk(pclk), .presetn(presetn), .sclk(sclk0), .cs_n(cs0), .mosi(mosi),
        .miso(miso0), .miso_oe(oe0), .bus(bus0.slave)
    );

    spi_slave_byte_if #(.CPOL(1'b1), .CPHA(1'b1)) dut1 (
        .pclk(pclk), .presetn(presetn), .sclk(sclk1), .cs_n(cs1), .mosi(mosi),
        .miso(miso1), .miso_oe(oe1), .bus(bus1.slave)
    );

    // Byte feeders: offer queued bytes; an offer seen with tx_ready high at a
    // falling edge is taken on the next rising edge.
    always @(negedge pclk) begin
        if (!presetn) begin
            accp0 = 1'b0;
            accp1 = 1'b0;
            bus0.tx_valid = 1'b0;
            bus1.tx_valid = 1'b0;
            bus0.tx_data  = 8'h00;
            bus1.tx_data  = 8'h00;
        end else begin
            if (accp0 && fq0.size() != 0) void'(fq0.pop_front());
            if (accp1 && fq1.size() != 0) void'(fq1.pop_front());
            bus0.tx_valid = (fq0.size() != 0);
            bus1.tx_valid = (fq1.size() != 0);
            bus0.tx_data  = (fq0.size() != 0) ? fq0[0] : 8'h00;
            bus1.tx_data  = (fq1.size() != 0) ? fq1[0] : 8'h00;
            accp0 = bus0.tx_valid & bus0.tx_ready;
            accp1 = bus1.tx_valid & bus1.tx_ready;
        end
    end

    // Monitors: collect received bytes and count status pulses.
    always @(negedge pclk) begin
        if (bus0.rx_valid === 1'b1) rxq0.push_back(bus0.rx_data);
        if (bus1.rx_valid === 1'b1) rxq1.push_back(bus1.rx_data);
        if (bus0.tx_underrun === 1'b1) und0++;
        if (bus1.tx_underrun === 1'b1) und1++;
        if (bus0.frame_end === 1'b1) fe0++;
        if (bus1.frame_end === 1'b1) fe1++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge pclk);
    endtask

    task automatic set_cs(input int sel, input logic v);
        if (sel == 0) cs0 = v; else cs1 = v;
    endtask

    function automatic logic get_active(input int sel);
        return (sel == 0) ? bus0.frame_active : bus1.frame_active;
    endfunction

    task automatic push_tx(input int sel, input logic [7:0] b);
        if (sel == 0) begin fq0.push_back(b); av0.push_back(b); end
        else          begin fq1.push_back(b); av1.push_back(b); end
    endtask

    // Model of one load event.
    task automatic model_load(input int sel, output logic [7:0] b, inout int und);
        if (sel == 0) begin
            if (av0.size() != 0) b = av0.pop_front(); else begin b = 8'hFF; und++; end
        end else begin
            if (av1.size() != 0) b = av1.pop_front(); else begin b = 8'hFF; und++; end
        end
    endtask

    // Master: sends nbits of mbytes MSB first, records MISO into rdq.
    // abrupt (mode 0 only): last leading edge and cs_n release together.
    task automatic applyStimulus(input int sel, input int nbits, input bit drop_cs, input bit abrupt);
        logic [7:0] rb;
        logic bv;
        rdq.delete();
        rb = 8'h00;
        wait_clk(4);
        set_cs(sel, 1'b0);
        wait_clk(8);
        checkOutput($sformatf("frame_active_%0d", sel), get_active(sel), 1);
        checkOutput($sformatf("miso_oe_%0d", sel), (sel == 0) ? oe0 : oe1, 1);
        for (int b = 0; b < nbits; b++) begin
            bv = mbytes[b / 8][7 - (b % 8)];
            if (sel == 0) begin
                mosi = bv;
                wait_clk(H);
                rb = {rb[6:0], miso0};
                sclk0 = 1'b1;
                if (abrupt && b == nbits - 1) cs0 = 1'b1;
                wait_clk(H);
                sclk0 = 1'b0;
            end else begin
                sclk1 = 1'b0;
                mosi = bv;
                wait_clk(H);
                rb = {rb[6:0], miso1};
                sclk1 = 1'b1;
                wait_clk(H);
            end
            if (b % 8 == 7) begin
                rdq.push_back(rb);
                wait_clk(H);
            end
        end
        wait_clk(8);
        if (drop_cs && !abrupt) set_cs(sel, 1'b1);
        wait_clk(8);
    endtask

    task automatic run_and_check(input string name, input int sel, input int nbits, input bit abrupt);
        int nfull, nloads, und_exp, und_before, fe_before;
        logic [7:0] lb;
        logic [7:0] exp_rd[$];
        nfull = nbits / 8;
        if (sel == 0) nloads = abrupt ? nfull : 1 + nfull;
        else          nloads = nfull + (((nbits % 8) != 0) ? 1 : 0);
        und_exp = 0;
        for (int k = 0; k < nloads; k++) begin
            model_load(sel, lb, und_exp);
            if (k < nfull) exp_rd.push_back(lb);
        end
        rxq0.delete();
        rxq1.delete();
        und_before = (sel == 0) ? und0 : und1;
        fe_before  = (sel == 0) ? fe0 : fe1;
        applyStimulus(sel, nbits, 1'b1, abrupt);
        checkOutput({name, ":rx_count"}, (sel == 0) ? rxq0.size() : rxq1.size(), nfull);
        for (int i = 0; i < nfull; i++) begin
            checkOutput($sformatf("%s:rx%0d", name, i), (sel == 0) ? rxq0[i] : rxq1[i], mbytes[i]);
            checkOutput($sformatf("%s:miso%0d", name, i), rdq[i], exp_rd[i]);
        end
        checkOutput({name, ":underruns"}, ((sel == 0) ? und0 : und1) - und_before, und_exp);
        checkOutput({name, ":frame_end"}, ((sel == 0) ? fe0 : fe1) - fe_before, 1);
        checkOutput({name, ":idle"}, get_active(sel), 0);
    endtask

    initial begin
        int sel, nb, part;
        presetn = 1'b0;
        sclk0 = 1'b0; cs0 = 1'b1;
        sclk1 = 1'b1; cs1 = 1'b1;
        mosi = 1'b0;
        wait_clk(3);
        $display("[TB] checking reset values");
        checkOutput("rst_miso", miso0, 0);
        checkOutput("rst_miso_oe", oe0, 0);
        checkOutput("rst_rx_data", bus0.rx_data, 0);
        checkOutput("rst_rx_valid", bus0.rx_valid, 0);
        checkOutput("rst_tx_ready", bus0.tx_ready, 1);
        checkOutput("rst_tx_underrun", bus0.tx_underrun, 0);
        checkOutput("rst_frame_active", bus0.frame_active, 0);
        checkOutput("rst_frame_end", bus0.frame_end, 0);
        checkOutput("rst_tx_ready1", bus1.tx_ready, 1);
        checkOutput("rst_miso_oe1", oe1, 0);
        presetn = 1'b1;
        wait_clk(4);

        // Four bytes, nothing offered: every load is an underrun.
        mbytes = '{8'h01, 8'h02, 8'h04, 8'h08};
        run_and_check("m0_four", 0, 32, 1'b0);

        // Preloaded bytes go out in order, then the filler byte.
        push_tx(0, 8'hA5);
        push_tx(0, 8'h3C);
        mbytes = '{8'h96, 8'h69, 8'hE1};
        run_and_check("m0_preload", 0, 24, 1'b0);

        // Mode 3 instance.
        push_tx(1, 8'h5A);
        mbytes = '{8'hC3};
        run_and_check("m3_single", 1, 8, 1'b0);

        // Frame aborted after 5 bits, then a clean frame.
        mbytes = '{8'hF0};
        run_and_check("m0_partial", 0, 5, 1'b0);
        mbytes = '{8'h81};
        run_and_check("m0_after_partial", 0, 8, 1'b0);

        // Reset in the middle of a frame drops the holding register.
        push_tx(0, 8'h11);
        push_tx(0, 8'h22);
        wait_clk(6);
        mbytes = '{8'hA3};
        rxq0.delete();
        applyStimulus(0, 3, 1'b0, 1'b0);
        presetn = 1'b0;
        wait_clk(2);
        fq0.delete(); av0.delete();
        fq1.delete(); av1.delete();
        checkOutput("mid_rst_miso", miso0, 0);
        checkOutput("mid_rst_miso_oe", oe0, 0);
        checkOutput("mid_rst_rx_data", bus0.rx_data, 0);
        checkOutput("mid_rst_tx_ready", bus0.tx_ready, 1);
        checkOutput("mid_rst_frame_active", bus0.frame_active, 0);
        cs0 = 1'b1;
        sclk0 = 1'b0;
        wait_clk(4);
        presetn = 1'b1;
        wait_clk(6);
        checkOutput("mid_rst_no_rx", rxq0.size(), 0);
        checkOutput("post_rst_idle", bus0.frame_active, 0);
        mbytes = '{8'h7E};
        run_and_check("m0_after_reset", 0, 8, 1'b0);

        // Offers held off while the holding register is full; none lost.
        push_tx(0, 8'h10);
        push_tx(0, 8'h20);
        push_tx(0, 8'h30);
        mbytes = '{8'h55, 8'hAA, 8'h0F};
        run_and_check("m0_stream", 0, 24, 1'b0);

        // Last sample and cs_n release in the same cycle.
        push_tx(0, 8'hB7);
        mbytes = '{8'h12, 8'h34};
        run_and_check("m0_abrupt", 0, 16, 1'b1);

        // Randomised frames on both instances.
        for (int f = 0; f < 8; f++) begin
            sel  = $urandom_range(0, 1);
            nb   = $urandom_range(1, 3);
            part = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
            for (int p = $urandom_range(0, 3); p > 0; p--) push_tx(sel, 8'($urandom));
            mbytes.delete();
            for (int i = 0; i < nb + 1; i++) mbytes.push_back(8'($urandom));
            run_and_check($sformatf("rand%0d", f), sel, nb * 8 + part, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
